// File: rtl/mem_pkg.sv
// Purpose: shared widths and FSM state encoding for the line-memory responder.
// Latency: none (types and constants only).
// Backpressure: none.
package mem_pkg;

   localparam int LINE_W  = 128;
   localparam int MADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/mem_line_array.sv
// Purpose: synchronous single-port line storage, 2**IDX_W lines of LINE_W bits.
// Latency: read data registered one edge after rd_en; write lands at the enabled edge.
// Backpressure: none; the owner never asserts rd_en and wr_en together.
module mem_line_array
   import mem_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  addr,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   // Contents start at zero and are never touched by reset.
   logic [LINE_W-1:0] lines [2**IDX_W] = '{default: '0};

   // Line write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         lines[addr] <= wdata;
      end
   end

   // Registered read port; holds the last read line until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= lines[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Purpose: fixed-latency line memory behind a cache; one request in flight at a time.
// Latency: request accepted in IDLE cycle t -> one-cycle mem_ready pulse in cycle t+LATENCY.
// Backpressure: requests are only sampled in IDLE; inputs in BUSY/RESP are ignored.
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int IDX_W   = 8
) (
   input  logic               clk,
   input  logic               proc_reset,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [MADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0]  mem_wdata,
   output logic [LINE_W-1:0]  mem_rdata,
   output logic               mem_ready,
   output logic [31:0]        rd_cnt,
   output logic [31:0]        wr_cnt
);

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   state_t            state;
   logic [7:0]        cnt;
   logic              op_wr;
   logic [IDX_W-1:0]  idx_q;
   logic [LINE_W-1:0] wdata_q;

   logic              req;
   logic              arr_rd;
   logic              arr_wr;
   logic [IDX_W-1:0]  arr_addr;
   logic              unused_addr_bits;

   // Upper address bits alias away; fold them into a sink so intent is explicit.
   assign unused_addr_bits = ^mem_addr;

   assign req = mem_read | mem_write;

   // Array port control: read is launched on the edge entering RESP so the
   // registered line is visible during RESP; write commits on the edge leaving RESP.
   always_comb begin
      arr_addr = idx_q;
      arr_rd   = 1'b0;
      arr_wr   = 1'b0;
      if (state == IDLE) begin
         arr_addr = mem_addr[IDX_W-1:0];
      end
      if (!proc_reset) begin
         if (state == IDLE && req && !mem_write && LATENCY == 1) begin
            arr_rd = 1'b1;
         end
         if (state == BUSY && cnt == 8'd1 && !op_wr) begin
            arr_rd = 1'b1;
         end
         if (state == RESP && op_wr) begin
            arr_wr = 1'b1;
         end
      end
   end

   // Request FSM, latency counter, completion pulse and statistics.
   always_ff @(posedge clk) begin
      if (proc_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         mem_ready <= 1'b0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         op_wr     <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               mem_ready <= 1'b0;
               if (req) begin
                  // Read+write together is a write; the read is dropped.
                  op_wr   <= mem_write;
                  idx_q   <= mem_addr[IDX_W-1:0];
                  wdata_q <= mem_wdata;
                  cnt     <= LAT_M1;
                  if (LATENCY == 1) begin
                     state     <= RESP;
                     mem_ready <= 1'b1;
                     if (mem_write) wr_cnt <= wr_cnt + 32'd1;
                     else           rd_cnt <= rd_cnt + 32'd1;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 8'd1;
               if (cnt == 8'd1) begin
                  state     <= RESP;
                  mem_ready <= 1'b1;
                  if (op_wr) wr_cnt <= wr_cnt + 32'd1;
                  else       rd_cnt <= rd_cnt + 32'd1;
               end
            end
            RESP: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               mem_ready <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   mem_line_array #(
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (proc_reset),
      .rd_en (arr_rd),
      .wr_en (arr_wr),
      .addr  (arr_addr),
      .wdata (wdata_q),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: directed bench for mem_responder at LATENCY=4 and LATENCY=1.
// Latency: checks the exact request-to-ready distance of every transaction.
// Backpressure: one transaction at a time, back-to-back where noted.
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_rd, a_wr, b_rd, b_wr;
   logic [27:0]  a_addr, b_addr;
   logic [127:0] a_wdata, b_wdata, a_rdata, b_rdata;
   logic         a_ready, b_ready;
   logic [31:0]  a_rdc, a_wrc, b_rdc, b_wrc;

   mem_responder #(.LATENCY(4), .IDX_W(8)) dut_a (
      .clk(clk), .proc_reset(rst), .mem_read(a_rd), .mem_write(a_wr),
      .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
      .mem_ready(a_ready), .rd_cnt(a_rdc), .wr_cnt(a_wrc));

   mem_responder #(.LATENCY(1), .IDX_W(8)) dut_b (
      .clk(clk), .proc_reset(rst), .mem_read(b_rd), .mem_write(b_wr),
      .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
      .mem_ready(b_ready), .rd_cnt(b_rdc), .wr_cnt(b_wrc));

   localparam logic [127:0] D5  = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [127:0] A5  = {4{32'hA5A5A5A5}};
   localparam logic [127:0] L7  = {4{32'h77777777}};
   localparam logic [127:0] L9  = {4{32'h99999999}};
   localparam logic [127:0] DED = {4{32'hDEADBEEF}};
   localparam logic [127:0] L22 = {4{32'h22222222}};

   typedef struct {
      logic         rd;
      logic         wr;
      logic [27:0]  addr;
      logic [127:0] wdata;
      logic [127:0] exp_rdata;
      logic [31:0]  exp_rd;
      logic [31:0]  exp_wr;
   } vec_t;

   vec_t vecs [10];

   int n_vec = 0;
   int n_mis = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic rdy(input bit sel);
      return sel ? b_ready : a_ready;
   endfunction

   task automatic drive(input bit sel, input logic rd, input logic wr,
                        input logic [27:0] addr, input logic [127:0] wd);
      if (sel) begin
         b_rd = rd; b_wr = wr; b_addr = addr; b_wdata = wd;
      end else begin
         a_rd = rd; a_wr = wr; a_addr = addr; a_wdata = wd;
      end
   endtask

   // One-cycle request pulse, then count cycles until mem_ready (bounded).
   task automatic transact(input bit sel, input logic rd, input logic wr,
                           input logic [27:0] addr, input logic [127:0] wd,
                           output int lat);
      @(negedge clk);
      check("idle ready low", {127'd0, rdy(sel)}, 128'd0);
      drive(sel, rd, wr, addr, wd);
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 28'd0, 128'd0);
      lat = 1;
      while (rdy(sel) !== 1'b1 && lat < 300) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      int lat;
      int pulses;

      vecs[0] = '{1'b0, 1'b1, 28'd5,          D5,   128'd0, 32'd0, 32'd1};
      vecs[1] = '{1'b1, 1'b0, 28'd5,          '0,   D5,     32'd1, 32'd1};
      vecs[2] = '{1'b0, 1'b1, 28'h0000103,    A5,   D5,     32'd1, 32'd2};
      vecs[3] = '{1'b1, 1'b0, 28'h0000103,    '0,   A5,     32'd2, 32'd2};
      vecs[4] = '{1'b1, 1'b0, 28'd3,          '0,   A5,     32'd3, 32'd2};
      vecs[5] = '{1'b1, 1'b0, 28'd4,          '0,   128'd0, 32'd4, 32'd2};
      vecs[6] = '{1'b0, 1'b1, 28'd7,          L7,   128'd0, 32'd4, 32'd3};
      vecs[7] = '{1'b1, 1'b1, 28'd9,          L9,   128'd0, 32'd4, 32'd4};
      vecs[8] = '{1'b1, 1'b0, 28'd9,          '0,   L9,     32'd5, 32'd4};
      vecs[9] = '{1'b1, 1'b0, 28'hFFFFF07,    '0,   L7,     32'd6, 32'd4};

      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 28'd0, 128'd0);
      drive(1'b1, 1'b0, 1'b0, 28'd0, 128'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset ready", {127'd0, a_ready}, 128'd0);
      check("reset rdata", a_rdata, 128'd0);
      check("reset rd_cnt", {96'd0, a_rdc}, 128'd0);
      check("reset wr_cnt", {96'd0, a_wrc}, 128'd0);

      for (int i = 0; i < 10; i++) begin
         transact(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat);
         check($sformatf("v%0d latency", i), 128'(lat), 128'd4);
         check($sformatf("v%0d rdata", i), a_rdata, vecs[i].exp_rdata);
         check($sformatf("v%0d rd_cnt", i), {96'd0, a_rdc}, {96'd0, vecs[i].exp_rd});
         check($sformatf("v%0d wr_cnt", i), {96'd0, a_wrc}, {96'd0, vecs[i].exp_wr});
      end

      // Cache-style hold: read held until ready, address changed mid-flight.
      @(negedge clk);
      check("hold idle ready low", {127'd0, a_ready}, 128'd0);
      a_rd = 1'b1; a_addr = 28'd5;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 2) a_addr = 28'd7;
      end while (a_ready !== 1'b1 && lat < 300);
      a_rd = 1'b0;
      check("hold latency", 128'(lat), 128'd4);
      check("hold rdata", a_rdata, D5);
      check("hold rd_cnt", {96'd0, a_rdc}, 128'd7);
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (a_ready) pulses++;
      end
      check("hold extra ready", 128'(pulses), 128'd0);

      // Reset two cycles after a write is accepted: transaction must vanish.
      a_wr = 1'b1; a_addr = 28'd5; a_wdata = DED;
      @(negedge clk);
      a_wr = 1'b0; a_wdata = '0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (6) begin
         if (a_ready) pulses++;
         @(negedge clk);
      end
      check("abort ready", 128'(pulses), 128'd0);
      check("abort wr_cnt", {96'd0, a_wrc}, 128'd0);
      check("abort rd_cnt", {96'd0, a_rdc}, 128'd0);
      check("abort rdata", a_rdata, 128'd0);
      transact(1'b0, 1'b1, 1'b0, 28'd5, '0, lat);
      check("abort readback latency", 128'(lat), 128'd4);
      check("abort line intact", a_rdata, D5);
      check("abort readback rd_cnt", {96'd0, a_rdc}, 128'd1);

      // Write-back then line fill, back to back.
      transact(1'b0, 1'b0, 1'b1, 28'd12, L22, lat);
      transact(1'b0, 1'b1, 1'b0, 28'd12, '0, lat);
      check("wb-fill latency", 128'(lat), 128'd4);
      check("wb-fill rdata", a_rdata, L22);
      check("wb-fill wr_cnt", {96'd0, a_wrc}, 128'd1);
      check("wb-fill rd_cnt", {96'd0, a_rdc}, 128'd2);

      // LATENCY=1: simultaneous read+write is a write; then back-to-back read.
      transact(1'b1, 1'b1, 1'b1, 28'd2, L22, lat);
      check("l1 rw latency", 128'(lat), 128'd1);
      check("l1 rw wr_cnt", {96'd0, b_wrc}, 128'd1);
      check("l1 rw rd_cnt", {96'd0, b_rdc}, 128'd0);
      check("l1 rw rdata", b_rdata, 128'd0);
      transact(1'b1, 1'b1, 1'b0, 28'd2, '0, lat);
      check("l1 rd latency", 128'(lat), 128'd1);
      check("l1 rd rdata", b_rdata, L22);
      check("l1 rd rd_cnt", {96'd0, b_rdc}, 128'd1);
      @(negedge clk);
      check("l1 single pulse", {127'd0, b_ready}, 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from request acceptance to mem_ready; legal range 1..255.
REQ-002 SHALL have parameter IDX_W, default 8: line-index width; the array holds 2**IDX_W lines.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port proc_reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port mem_read, input, 1: line read request from the cache.
REQ-006 SHALL have port mem_write, input, 1: line write-back request from the cache.
REQ-007 SHALL have port mem_addr, input, 28: line address (word address bits 29:2).
REQ-008 SHALL have port mem_wdata, input, 128: write line, word0 in bits 31:0.
REQ-009 SHALL have port mem_rdata, output, 128: read line, same word ordering as mem_wdata.
REQ-010 SHALL have port mem_ready, output, 1: single-cycle completion pulse.
REQ-011 SHALL have ports rd_cnt and wr_cnt, each output, 32: completed read and write counts.

Function
REQ-012 SHALL implement FSM IDLE, BUSY, RESP; every output SHALL be driven from registers.
REQ-013 IDLE: a cycle with mem_read or mem_write high SHALL latch op, mem_addr and mem_wdata, load the counter with LATENCY-1, and go to BUSY; if LATENCY==1 it SHALL go directly to RESP.
REQ-014 BUSY: the counter SHALL decrement each cycle; on the cycle it reads 1 the FSM SHALL go to RESP. Request inputs SHALL be ignored, including deassertion and changes to address or data.
REQ-015 RESP: mem_ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; a request accepted in IDLE cycle t SHALL produce mem_ready in cycle t+LATENCY.
REQ-016 Read: in the RESP cycle, mem_rdata SHALL equal array[latched_addr[IDX_W-1:0]]; mem_rdata SHALL hold its value until the next read response.
REQ-017 Write: latched data SHALL commit to the array at the rising edge that ends the RESP cycle; mem_rdata SHALL be unchanged.
REQ-018 mem_read and mem_write high together SHALL be treated as a write; the read is dropped and is not counted.
REQ-019 A request high in the cycle immediately after RESP SHALL be accepted as a new request; back-to-back write-then-read returns the newly written line.
REQ-020 Address bits 27:IDX_W SHALL be ignored; lines alias modulo 2**IDX_W.
REQ-021 rd_cnt and wr_cnt SHALL increment in the RESP cycle of a read or write respectively, and SHALL wrap from 2**32-1 to 0.
REQ-022 Array contents SHALL be zero at time zero.

Reset
REQ-023 When proc_reset is high at an edge, the block SHALL set state=IDLE, mem_ready=0, mem_rdata=0, rd_cnt=0, wr_cnt=0, and counter=0.
REQ-024 Reset SHALL NOT modify array contents.
REQ-025 A reset during BUSY or RESP SHALL abort the transaction: no commit, no count, and no mem_ready in the following cycle.
REQ-026 With reset deasserted, the first cycle SHALL be IDLE and able to accept a request.

Structure
REQ-027 Shared package mem_pkg SHALL hold: LINE_W=128, MADDR_W=28, and the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
REQ-028 Storage SHALL be a sub-module mem_line_array: a synchronous single-port 2**IDX_W x 128 array. FSM, counter and statistics SHALL live in mem_responder.

Verification
REQ-029 Read, LATENCY=4: preload line 5 = 128'h0123...CDEF, pulse mem_read with mem_addr=5 at cycle 10 -> mem_ready high only in cycle 14, mem_rdata=128'h0123...CDEF, rd_cnt=1.
REQ-030 Write then read: write 128'hA5A5... to addr 28'h0000_103, then issue a read in the cycle after ready -> read returns 128'hA5A5..., wr_cnt=1, rd_cnt=1; a read of addr 3 (alias, IDX_W=8) returns the same line.
REQ-031 Cache-style handshake: hold mem_read until mem_ready, change mem_addr to 7 during BUSY -> the line at the originally latched address is returned, and exactly one mem_ready pulse occurs.
REQ-032 Reset mid-operation: mem_write accepted, proc_reset high 2 cycles later -> no mem_ready, the target line is unchanged, wr_cnt=0, and the FSM is in IDLE.
REQ-033 LATENCY=1 and simultaneous read+write: request at cycle t -> mem_ready at t+1, treated as a write, rd_cnt unchanged.
REQ-034 Integration: connect to the 2-way cache and run a read miss on a dirty set -> one write-back, then one line read; the processor read returns the memory line.
